// File: rtl/fpu_ss_issue_scoreboard_if.sv
// Purpose: issue, FU-request, writeback and forwarding bundle of the FPU issue scoreboard.
// Ports: issue_* (decoded instruction in, issue_ready out), fu_valid/fu_ready request to the FU,
//        wb_* per writeback port, fpr_we per port, fwd_valid/fwd_port per source operand.
interface fpu_ss_issue_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int NUM_OPS  = 3,
  parameter int NUM_WB   = 2
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int WW = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [NUM_OPS*AW-1:0] issue_rs_i;
  logic [NUM_OPS-1:0]    issue_rs_used_i;
  logic [AW-1:0]         issue_rd_i;
  logic                  issue_rd_fp_i;
  logic                  fu_valid_o;
  logic                  fu_ready_i;
  logic [NUM_WB-1:0]     wb_valid_i;
  logic [NUM_WB-1:0]     wb_ready_o;
  logic [NUM_WB*AW-1:0]  wb_addr_i;
  logic [NUM_WB-1:0]     wb_fp_i;
  logic [NUM_WB-1:0]     fpr_we_o;
  logic [NUM_OPS-1:0]    fwd_valid_o;
  logic [NUM_OPS*WW-1:0] fwd_port_o;

  // Driver side: decoder, functional units and writeback sources.
  modport master (
    output issue_valid_i, issue_rs_i, issue_rs_used_i, issue_rd_i, issue_rd_fp_i,
    output fu_ready_i, wb_valid_i, wb_addr_i, wb_fp_i,
    input  issue_ready_o, fu_valid_o, wb_ready_o, fpr_we_o, fwd_valid_o, fwd_port_o
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid_i, issue_rs_i, issue_rs_used_i, issue_rd_i, issue_rd_fp_i,
    input  fu_ready_i, wb_valid_i, wb_addr_i, wb_fp_i,
    output issue_ready_o, fu_valid_o, wb_ready_o, fpr_we_o, fwd_valid_o, fwd_port_o
  );
endinterface

// File: rtl/fpu_ss_issue_scoreboard.sv
// Purpose: gates FPU instruction issue on a per-FP-register scoreboard and an outstanding-op
//          limit, accepts NUM_WB writeback ports and forwards same-cycle FP writebacks.
// Ports: clk_i/rst_ni (async active-low), flush_i sync kill, bus_if (issue/FU/writeback/forward),
//        outstanding_o count, busy_o, err_o sticky underflow flag. Issue decision is combinational.
module fpu_ss_issue_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int NUM_OPS         = 3,
  parameter int NUM_WB          = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter bit FORWARDING      = 1'b1,
  parameter bit OUT_OF_ORDER    = 1'b1,
  localparam int AW = $clog2(NUM_REGS),
  localparam int WW = (NUM_WB > 1) ? $clog2(NUM_WB) : 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  fpu_ss_issue_scoreboard_if.slave     bus_if,
  output logic [CW-1:0]                outstanding_o,
  output logic                         busy_o,
  output logic                         err_o
);
  localparam int PW = $clog2(NUM_WB + 1);
  localparam int SW = CW + PW + 1;

  logic [NUM_REGS-1:0]   r_sb;
  logic [CW-1:0]         r_cnt;
  logic                  r_err;

  logic [NUM_WB-1:0]     w_wb_ready;
  logic [NUM_WB-1:0]     w_fire;
  logic [NUM_WB-1:0]     w_fp_fire;
  logic [PW-1:0]         w_pop;
  logic                  w_any_fire;
  logic [NUM_OPS-1:0]    w_hit;
  logic [NUM_OPS*WW-1:0] w_hit_port;
  logic [NUM_OPS-1:0]    w_fwd_valid;
  logic [NUM_OPS*WW-1:0] w_fwd_port;
  logic                  w_raw_unres;
  logic                  w_rd_clr;
  logic                  w_waw;
  logic                  w_room;
  logic                  w_order_ok;
  logic                  w_fu_valid;
  logic                  w_issue_fire;
  logic [NUM_REGS-1:0]   w_sb_next;
  logic [SW-1:0]         w_sum;
  logic                  w_underflow;
  logic [CW-1:0]         w_cnt_next;

  // Two FP writebacks to one register in the same cycle would race in the RF:
  // the lowest port wins and the higher one is back-pressured for a retry.
  always_comb begin
    w_wb_ready = '1;
    for (int p = 1; p < NUM_WB; p++) begin
      for (int q = 0; q < p; q++) begin
        if (bus_if.wb_valid_i[q] && bus_if.wb_fp_i[q] && bus_if.wb_fp_i[p] &&
            (bus_if.wb_addr_i[q*AW +: AW] == bus_if.wb_addr_i[p*AW +: AW]))
          w_wb_ready[p] = 1'b0;
      end
    end
  end

  assign w_fire     = bus_if.wb_valid_i & w_wb_ready;
  assign w_fp_fire  = w_fire & bus_if.wb_fp_i;
  assign w_any_fire = |w_fire;

  always_comb begin
    w_pop = '0;
    for (int p = 0; p < NUM_WB; p++) w_pop = w_pop + PW'(w_fire[p]);
  end

  // Per operand: lowest FP port firing to rs_k (descending scan so lowest overwrites last).
  always_comb begin
    w_hit       = '0;
    w_hit_port  = '0;
    w_fwd_valid = '0;
    w_fwd_port  = '0;
    w_raw_unres = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (w_fp_fire[p] && (bus_if.wb_addr_i[p*AW +: AW] == bus_if.issue_rs_i[k*AW +: AW])) begin
          w_hit[k]                = 1'b1;
          w_hit_port[k*WW +: WW]  = WW'(p);
        end
      end
      if (bus_if.issue_rs_used_i[k] && r_sb[bus_if.issue_rs_i[k*AW +: AW]]) begin
        if (FORWARDING && w_hit[k]) begin
          w_fwd_valid[k]          = 1'b1;
          w_fwd_port[k*WW +: WW]  = w_hit_port[k*WW +: WW];
        end else begin
          w_raw_unres = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rd_clr = 1'b0;
    for (int p = 0; p < NUM_WB; p++)
      if (w_fp_fire[p] && (bus_if.wb_addr_i[p*AW +: AW] == bus_if.issue_rd_i)) w_rd_clr = 1'b1;
  end

  assign w_waw        = bus_if.issue_rd_fp_i & r_sb[bus_if.issue_rd_i] & ~w_rd_clr;
  // A retire in the same cycle frees a slot, so a full window can still accept one issue.
  assign w_room       = (r_cnt < CW'(MAX_OUTSTANDING)) |
                        ((r_cnt == CW'(MAX_OUTSTANDING)) & w_any_fire);
  assign w_order_ok   = OUT_OF_ORDER | (r_cnt == '0) | ((r_cnt == CW'(1)) & w_any_fire);
  assign w_fu_valid   = bus_if.issue_valid_i & ~flush_i & ~w_raw_unres & ~w_waw & w_room & w_order_ok;
  assign w_issue_fire = w_fu_valid & bus_if.fu_ready_i;

  // Clears first, then the issue set, so a same-address set/clear leaves the bit busy.
  always_comb begin
    w_sb_next = r_sb;
    for (int p = 0; p < NUM_WB; p++)
      if (w_fp_fire[p]) w_sb_next[bus_if.wb_addr_i[p*AW +: AW]] = 1'b0;
    if (w_issue_fire && bus_if.issue_rd_fp_i) w_sb_next[bus_if.issue_rd_i] = 1'b1;
  end

  assign w_sum       = SW'(r_cnt) + SW'(w_issue_fire);
  assign w_underflow = (w_sum < SW'(w_pop));
  assign w_cnt_next  = w_underflow ? '0 : CW'(w_sum - SW'(w_pop));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sb  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (flush_i) begin
      r_sb  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_sb  <= w_sb_next;
      r_cnt <= w_cnt_next;
      r_err <= r_err | w_underflow;
    end
  end

  assign bus_if.wb_ready_o    = w_wb_ready;
  assign bus_if.fpr_we_o      = w_fp_fire & {NUM_WB{~flush_i}};
  assign bus_if.fwd_valid_o   = w_fwd_valid;
  assign bus_if.fwd_port_o    = w_fwd_port;
  assign bus_if.fu_valid_o    = w_fu_valid;
  assign bus_if.issue_ready_o = w_issue_fire;
  assign outstanding_o        = r_cnt;
  assign busy_o               = (r_cnt != '0);
  assign err_o                = r_err;
endmodule

// File: tb/tb_fpu_ss_issue_scoreboard.sv
module tb_fpu_ss_issue_scoreboard;
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [4:0] r0, r1, r2;
    logic [2:0] used;
    logic [4:0] rd;
    logic       rdfp;
    logic       fr;
    logic [1:0] wv;
    logic [4:0] a0, a1;
    logic [1:0] wfp;
    logic       e_fv, e_ir;
    logic [1:0] e_wr, e_we;
    logic [2:0] e_fwv, e_fwp;
    logic [2:0] e_cnt;
    logic       e_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Shared stimulus, steered to DUT A (FORWARDING=1, OUT_OF_ORDER=1) or DUT B (both 0).
  logic       sel_b = 1'b0;
  logic       d_fl = 0, d_iv = 0, d_rdfp = 0, d_fr = 0;
  logic [14:0] d_rs = '0;
  logic [2:0] d_used = '0;
  logic [4:0] d_rd = '0;
  logic [1:0] d_wv = '0, d_wfp = '0;
  logic [9:0] d_wa = '0;

  fpu_ss_issue_scoreboard_if #(.NUM_REGS(32), .NUM_OPS(3), .NUM_WB(2)) ifa ();
  fpu_ss_issue_scoreboard_if #(.NUM_REGS(32), .NUM_OPS(3), .NUM_WB(2)) ifb ();

  logic       fla, flb;
  logic [2:0] cnt_a, cnt_b;
  logic       busy_a, busy_b, err_a, err_b;

  assign fla = sel_b ? 1'b0 : d_fl;
  assign flb = sel_b ? d_fl : 1'b0;
  assign ifa.issue_valid_i   = sel_b ? 1'b0  : d_iv;
  assign ifa.issue_rs_i      = sel_b ? 15'd0 : d_rs;
  assign ifa.issue_rs_used_i = sel_b ? 3'd0  : d_used;
  assign ifa.issue_rd_i      = sel_b ? 5'd0  : d_rd;
  assign ifa.issue_rd_fp_i   = sel_b ? 1'b0  : d_rdfp;
  assign ifa.fu_ready_i      = sel_b ? 1'b0  : d_fr;
  assign ifa.wb_valid_i      = sel_b ? 2'd0  : d_wv;
  assign ifa.wb_addr_i       = sel_b ? 10'd0 : d_wa;
  assign ifa.wb_fp_i         = sel_b ? 2'd0  : d_wfp;
  assign ifb.issue_valid_i   = sel_b ? d_iv   : 1'b0;
  assign ifb.issue_rs_i      = sel_b ? d_rs   : 15'd0;
  assign ifb.issue_rs_used_i = sel_b ? d_used : 3'd0;
  assign ifb.issue_rd_i      = sel_b ? d_rd   : 5'd0;
  assign ifb.issue_rd_fp_i   = sel_b ? d_rdfp : 1'b0;
  assign ifb.fu_ready_i      = sel_b ? d_fr   : 1'b0;
  assign ifb.wb_valid_i      = sel_b ? d_wv   : 2'd0;
  assign ifb.wb_addr_i       = sel_b ? d_wa   : 10'd0;
  assign ifb.wb_fp_i         = sel_b ? d_wfp  : 2'd0;

  fpu_ss_issue_scoreboard #(.FORWARDING(1'b1), .OUT_OF_ORDER(1'b1)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(fla), .bus_if(ifa),
    .outstanding_o(cnt_a), .busy_o(busy_a), .err_o(err_a));

  fpu_ss_issue_scoreboard #(.FORWARDING(1'b0), .OUT_OF_ORDER(1'b0)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flb), .bus_if(ifb),
    .outstanding_o(cnt_b), .busy_o(busy_b), .err_o(err_b));

  function automatic vec_t mk(logic fl, logic iv, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                              logic [2:0] used, logic [4:0] rd, logic rdfp, logic fr,
                              logic [1:0] wv, logic [4:0] a0, logic [4:0] a1, logic [1:0] wfp,
                              logic e_fv, logic e_ir, logic [1:0] e_wr, logic [1:0] e_we,
                              logic [2:0] e_fwv, logic [2:0] e_fwp, logic [2:0] e_cnt, logic e_err);
    vec_t v;
    v.fl = fl; v.iv = iv; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.used = used; v.rd = rd;
    v.rdfp = rdfp; v.fr = fr; v.wv = wv; v.a0 = a0; v.a1 = a1; v.wfp = wfp;
    v.e_fv = e_fv; v.e_ir = e_ir; v.e_wr = e_wr; v.e_we = e_we; v.e_fwv = e_fwv;
    v.e_fwp = e_fwp; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector mid-cycle, check combinational outputs and current state before the next edge.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk_i);
    d_fl = v.fl; d_iv = v.iv; d_rs = {v.r2, v.r1, v.r0}; d_used = v.used; d_rd = v.rd;
    d_rdfp = v.rdfp; d_fr = v.fr; d_wv = v.wv; d_wa = {v.a1, v.a0}; d_wfp = v.wfp;
    #2;
    chk({tag, " fu_valid"},    sel_b ? ifb.fu_valid_o    : ifa.fu_valid_o,    v.e_fv);
    chk({tag, " issue_ready"}, sel_b ? ifb.issue_ready_o : ifa.issue_ready_o, v.e_ir);
    chk({tag, " wb_ready"},    sel_b ? ifb.wb_ready_o    : ifa.wb_ready_o,    v.e_wr);
    chk({tag, " fpr_we"},      sel_b ? ifb.fpr_we_o      : ifa.fpr_we_o,      v.e_we);
    chk({tag, " fwd_valid"},   sel_b ? ifb.fwd_valid_o   : ifa.fwd_valid_o,   v.e_fwv);
    chk({tag, " fwd_port"},    sel_b ? ifb.fwd_port_o    : ifa.fwd_port_o,    v.e_fwp);
    chk({tag, " outstanding"}, sel_b ? cnt_b  : cnt_a,  v.e_cnt);
    chk({tag, " busy"},        sel_b ? busy_b : busy_a, (v.e_cnt != 3'd0));
    chk({tag, " err"},         sel_b ? err_b  : err_a,  v.e_err);
  endtask

  vec_t tbl[$];

  initial begin
    //            fl iv r0 r1 r2 used   rd fp fr wv    a0 a1 wfp    fv ir wr     we     fwv     fwp    cnt err
    tbl.push_back(mk(0,0, 0, 0, 0,3'b000, 0,0,0,2'b00, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd0,0)); // reset
    tbl.push_back(mk(0,1, 2, 3, 0,3'b011, 1,1,1,2'b00, 0, 0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd0,0)); // f1=f2+f3
    tbl.push_back(mk(0,0, 0, 0, 0,3'b000, 0,0,0,2'b01, 1, 0,2'b01, 0,0,2'b11,2'b01,3'b000,3'b000,3'd1,0)); // wb f1
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000, 5,1,1,2'b00, 0, 0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd0,0)); // sb5
    tbl.push_back(mk(0,1, 5, 0, 0,3'b001, 6,1,1,2'b10, 0, 5,2'b10, 1,1,2'b11,2'b10,3'b001,3'b001,3'd1,0)); // fwd p1
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000, 6,1,1,2'b00, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd1,0)); // WAW
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000, 6,1,1,2'b01, 6, 0,2'b01, 1,1,2'b11,2'b01,3'b000,3'b000,3'd1,0)); // WAW cleared
    tbl.push_back(mk(0,1, 0, 6, 0,3'b010, 7,0,1,2'b00, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd1,0)); // RAW held
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000, 8,0,1,2'b00, 0, 0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd1,0));
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000, 8,0,1,2'b00, 0, 0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd2,0));
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000, 8,0,1,2'b00, 0, 0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd3,0));
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000, 8,0,1,2'b00, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd4,0)); // full
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000, 8,0,1,2'b01, 0, 0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd4,0)); // retire+issue
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000, 8,0,1,2'b11, 7, 7,2'b11, 1,1,2'b01,2'b01,3'b000,3'b000,3'd4,0)); // wb clash
    tbl.push_back(mk(0,0, 0, 0, 0,3'b000, 0,0,0,2'b10, 0, 7,2'b10, 0,0,2'b11,2'b10,3'b000,3'b000,3'd4,0)); // p1 retry
    tbl.push_back(mk(1,1, 0, 0, 0,3'b000, 9,1,1,2'b01, 6, 0,2'b01, 0,0,2'b11,2'b00,3'b000,3'b000,3'd3,0)); // flush
    tbl.push_back(mk(0,1, 6, 0, 0,3'b001, 6,1,1,2'b00, 0, 0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd0,0)); // sb cleared
    tbl.push_back(mk(0,0, 0, 0, 0,3'b000, 0,0,0,2'b01, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd1,0));
    tbl.push_back(mk(0,0, 0, 0, 0,3'b000, 0,0,0,2'b10, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd0,0)); // underflow
    tbl.push_back(mk(0,0, 0, 0, 0,3'b000, 0,0,0,2'b00, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd0,1));
    tbl.push_back(mk(0,0, 0, 0, 0,3'b000, 0,0,0,2'b00, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd0,1)); // sticky
    tbl.push_back(mk(1,0, 0, 0, 0,3'b000, 0,0,0,2'b00, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd0,1)); // flush
    tbl.push_back(mk(0,0, 0, 0, 0,3'b000, 0,0,0,2'b00, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd0,0));
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000, 9,1,1,2'b00, 0, 0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd0,0));
    tbl.push_back(mk(0,1, 0, 0, 0,3'b000,10,1,1,2'b00, 0, 0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd1,0));
    tbl.push_back(mk(0,1,10, 0, 9,3'b101,11,0,1,2'b11, 9,10,2'b11, 1,1,2'b11,2'b11,3'b101,3'b001,3'd2,0)); // 2 fwds
    tbl.push_back(mk(0,0, 0, 0, 0,3'b000, 0,0,0,2'b00, 0, 0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd1,0));

    #12 rst_ni = 1'b1;
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("A%0d", i), tbl[i]);

    // No forwarding, in-order issue.
    sel_b = 1'b1;
    apply("B0", mk(0,0,0,0,0,3'b000,0,0,0,2'b00,0,0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd0,0));
    apply("B1", mk(0,1,0,0,0,3'b000,5,1,1,2'b00,0,0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd0,0));
    apply("B2", mk(0,1,5,0,0,3'b001,6,1,1,2'b10,0,5,2'b10, 0,0,2'b11,2'b10,3'b000,3'b000,3'd1,0));
    apply("B3", mk(0,1,5,0,0,3'b001,6,1,1,2'b00,0,0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd0,0));
    apply("B4", mk(0,1,0,0,0,3'b000,7,0,1,2'b00,0,0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd1,0));
    apply("B5", mk(0,1,0,0,0,3'b000,7,0,1,2'b01,0,0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd1,0));
    apply("B6", mk(0,0,0,0,0,3'b000,0,0,0,2'b11,0,0,2'b00, 0,0,2'b11,2'b00,3'b000,3'b000,3'd1,0));
    apply("B7", mk(0,1,0,0,0,3'b000,3,1,1,2'b00,0,0,2'b00, 1,1,2'b11,2'b00,3'b000,3'b000,3'd0,1));

    // Asynchronous reset between edges with both DUTs holding an outstanding op.
    @(negedge clk_i);
    d_iv = 1'b0; d_fr = 1'b0;
    chk("pre-reset cnt_b", cnt_b, 3'd1);
    chk("pre-reset cnt_a", cnt_a, 3'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async reset cnt_a", cnt_a, 3'd0);
    chk("async reset cnt_b", cnt_b, 3'd0);
    chk("async reset err_b", err_b, 1'b0);
    chk("async reset busy_b", busy_b, 1'b0);
    #10 rst_ni = 1'b1;
    #10;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
